// File: rtl/pkt_dispatch.sv
// Packet dispatcher: buffers incoming packets, classifies them through a
// programmable type table and holds per-block enables until each block reports done.
module pkt_dispatch #(
    parameter int unsigned   TYPE_W     = 3,
    parameter int unsigned   ID_W       = 16,
    parameter int unsigned   N_DEST     = 4,
    parameter int unsigned   FIFO_DEPTH = 4,
    parameter logic [ID_W-1:0] BCAST_ID = {ID_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              newpkt,
    input  logic [TYPE_W-1:0] fPktType,
    input  logic [ID_W-1:0]   destinationID,
    input  logic [ID_W-1:0]   myNodeID,
    input  logic              cfg_we,
    input  logic [TYPE_W-1:0] cfg_type,
    input  logic [2*N_DEST-1:0] cfg_mask,
    input  logic [N_DEST-1:0] dest_done,
    output logic [N_DEST-1:0] en_out,
    output logic              iAmDestination,
    output logic [TYPE_W-1:0] pkt_type_out,
    output logic              busy,
    output logic              full,
    output logic [7:0]        drop_cnt
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = TYPE_W + 1;
    localparam int unsigned NT = 2 ** TYPE_W;
    localparam int unsigned MW = 2 * N_DEST;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_DISPATCH = 1'b1
    } state_t;

    // Power-on contents of the type table: {gated, unconditional}.
    function automatic logic [MW-1:0] tbl_default(input int unsigned idx);
        logic [MW-1:0] m;
        m = '0;
        case (idx)
            0, 4: m[3:0] = 4'b1010;
            1:    m[3:0] = 4'b0110;
            2:    m[3:0] = 4'b1100;
            3:    m[3:0] = 4'b1001;
            5, 6: begin
                m[0]        = 1'b1;
                m[N_DEST+3] = 1'b1;
            end
            default: m = '0;
        endcase
        return m;
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [EW-1:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wp;
    logic [AW-1:0]       r_rp;
    logic [CW-1:0]       r_cnt;
    logic                r_full;
    logic [7:0]          r_drop;
    logic [MW-1:0]       r_tbl [NT];
    logic [N_DEST-1:0]   r_pend;
    logic                r_iam;
    logic [TYPE_W-1:0]   r_type;

    logic                w_empty;
    logic                w_full_now;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic                w_match;
    logic [EW-1:0]       w_head;
    logic [MW-1:0]       w_entry;
    logic [N_DEST-1:0]   w_mask;
    logic [N_DEST-1:0]   w_pend_nxt;
    logic [CW-1:0]       w_cnt_nxt;

    assign w_empty    = (r_cnt == '0);
    assign w_full_now = (r_cnt == CW'(FIFO_DEPTH));
    assign w_match    = (destinationID == myNodeID) || (destinationID == BCAST_ID);
    assign w_push     = newpkt && (!w_full_now || w_pop);
    assign w_drop     = newpkt && w_full_now && !w_pop;
    assign w_cnt_nxt  = r_cnt + CW'(w_push) - CW'(w_pop);

    // Head entry layout: {type, match}; table read sees the pre-write value.
    assign w_head  = r_mem[r_rp];
    assign w_entry = r_tbl[w_head[EW-1:1]];
    assign w_mask  = w_entry[N_DEST-1:0] | (w_entry[MW-1:N_DEST] & {N_DEST{w_head[0]}});

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (!w_empty && (w_mask != '0)) w_state_nxt = S_DISPATCH;
            S_DISPATCH: if ((r_pend & ~dest_done) == '0) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_pop      = 1'b0;
        w_pend_nxt = r_pend;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_pend_nxt = w_mask;
                end
            end
            S_DISPATCH: w_pend_nxt = r_pend & ~dest_done;
            default:    w_pend_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
            r_iam  <= 1'b0;
            r_type <= '0;
        end else begin
            r_pend <= w_pend_nxt;
            if (w_pop) begin
                r_iam  <= w_head[0];
                r_type <= w_head[EW-1:1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            r_full <= 1'b0;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop)  r_rp <= r_rp + AW'(1);
            r_cnt  <= w_cnt_nxt;
            r_full <= (w_cnt_nxt == CW'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) r_mem[r_wp] <= {fPktType, w_match};
    end

    always_ff @(posedge clk) begin
        if (rst)                         r_drop <= '0;
        else if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NT; i++) r_tbl[i] <= tbl_default(i);
        end else if (cfg_we) begin
            r_tbl[cfg_type] <= cfg_mask;
        end
    end

    assign en_out         = r_pend;
    assign iAmDestination = r_iam;
    assign pkt_type_out   = r_type;
    assign busy           = (r_state == S_DISPATCH);
    assign full           = r_full;
    assign drop_cnt       = r_drop;

endmodule

// File: tb/tb_pkt_dispatch.sv
// Randomized and directed bench for pkt_dispatch with a queue-based reference
// model and a dispatch scoreboard checked by an independent monitor.
module tb_pkt_dispatch;

    localparam int unsigned TYPE_W = 3;
    localparam int unsigned ID_W   = 16;
    localparam int unsigned N_DEST = 4;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              newpkt;
    logic [TYPE_W-1:0] fPktType;
    logic [ID_W-1:0]   destinationID;
    logic [ID_W-1:0]   myNodeID;
    logic              cfg_we;
    logic [TYPE_W-1:0] cfg_type;
    logic [7:0]        cfg_mask;
    logic [N_DEST-1:0] dest_done;
    logic [N_DEST-1:0] en_out;
    logic              iAmDestination;
    logic [TYPE_W-1:0] pkt_type_out;
    logic              busy;
    logic              full;
    logic [7:0]        drop_cnt;

    always #5 clk = ~clk;

    pkt_dispatch #(
        .TYPE_W(TYPE_W), .ID_W(ID_W), .N_DEST(N_DEST), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .newpkt(newpkt), .fPktType(fPktType),
        .destinationID(destinationID), .myNodeID(myNodeID),
        .cfg_we(cfg_we), .cfg_type(cfg_type), .cfg_mask(cfg_mask),
        .dest_done(dest_done), .en_out(en_out), .iAmDestination(iAmDestination),
        .pkt_type_out(pkt_type_out), .busy(busy), .full(full), .drop_cnt(drop_cnt)
    );

    typedef struct { logic [2:0] t; logic m; } pkt_t;
    typedef struct { logic [3:0] en; logic iam; logic [2:0] t; } disp_t;

    pkt_t       mq[$];
    disp_t      sb[$];
    logic [7:0] mtbl [8];
    bit         m_busy;
    logic [3:0] m_pend;
    logic       m_iam;
    logic [2:0] m_type;
    int         m_drop;
    int         vectors = 0;
    int         errors  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_busy = 0;
        m_pend = '0;
        m_iam  = 1'b0;
        m_type = '0;
        m_drop = 0;
        mtbl   = '{8'h0A, 8'h06, 8'h0C, 8'h09, 8'h0A, 8'h81, 8'h81, 8'h00};
    endtask

    // Reference behaviour for one clock edge, given the inputs now applied.
    task automatic model_update();
        pkt_t       p;
        logic [7:0] ent;
        logic [3:0] mask;
        disp_t      d;
        if (rst) begin
            model_reset();
            return;
        end
        if (!m_busy && mq.size() > 0) begin
            p    = mq.pop_front();
            ent  = mtbl[p.t];
            mask = ent[3:0] | (p.m ? ent[7:4] : 4'b0000);
            m_iam  = p.m;
            m_type = p.t;
            if (mask != 4'b0000) begin
                m_busy = 1;
                m_pend = mask;
                d.en = mask; d.iam = p.m; d.t = p.t;
                sb.push_back(d);
            end
        end else if (m_busy) begin
            m_pend = m_pend & ~dest_done;
            if (m_pend == 4'b0000) m_busy = 0;
        end
        if (cfg_we) mtbl[cfg_type] = cfg_mask;
        if (newpkt) begin
            if (mq.size() < DEPTH) begin
                p.t = fPktType;
                p.m = (destinationID == myNodeID) || (destinationID == 16'hFFFF);
                mq.push_back(p);
            end else if (m_drop < 255) begin
                m_drop++;
            end
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        @(negedge clk);
        chk("en_out", 32'(en_out), 32'(m_pend));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("full", 32'(full), 32'(mq.size() == DEPTH));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        chk("iAmDestination", 32'(iAmDestination), 32'(m_iam));
        chk("pkt_type_out", 32'(pkt_type_out), 32'(m_type));
        rst = 1'b0; newpkt = 1'b0; cfg_we = 1'b0; dest_done = '0;
    endtask

    task automatic send(input logic [2:0] t, input logic [15:0] dst);
        newpkt = 1'b1; fPktType = t; destinationID = dst;
        step();
    endtask

    // Monitor: each new dispatch must match the oldest expected dispatch.
    logic  mon_prev_busy = 1'b0;
    disp_t mon_e;
    always @(negedge clk) begin
        if (busy === 1'b1 && mon_prev_busy === 1'b0) begin
            if (sb.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL dispatch: unexpected en_out=%0h at %0t", en_out, $time);
            end else begin
                mon_e = sb.pop_front();
                chk("dispatch_en", 32'(en_out), 32'(mon_e.en));
                chk("dispatch_iam", 32'(iAmDestination), 32'(mon_e.iam));
                chk("dispatch_type", 32'(pkt_type_out), 32'(mon_e.t));
            end
        end
        mon_prev_busy = busy;
    end

    initial begin
        rst = 1'b1; newpkt = 1'b0; fPktType = '0; destinationID = '0;
        myNodeID = 16'h1234; cfg_we = 1'b0; cfg_type = '0; cfg_mask = '0; dest_done = '0;
        model_reset();
        step();
        chk("reset_en", 32'(en_out), 32'h0);

        // Type 001: enables two edges after newpkt, held until done.
        send(3'd1, 16'h0042);
        step();
        chk("t001_en", 32'(en_out), 32'h6);
        step(); step();
        chk("t001_hold", 32'(en_out), 32'h6);
        dest_done = 4'b0110; step();
        chk("t001_release", 32'(en_out), 32'h0);

        // Type 101 with destination gating.
        send(3'd5, 16'h0042); step();
        chk("t101_nomatch", 32'(en_out), 32'h1);
        dest_done = 4'b0001; step();
        send(3'd5, 16'h1234); step();
        chk("t101_match", 32'(en_out), 32'h9);
        chk("t101_iam", 32'(iAmDestination), 32'h1);
        dest_done = 4'b1001; step();
        send(3'd5, 16'hFFFF); step();
        chk("t101_bcast", 32'(en_out), 32'h9);
        dest_done = 4'b1111; step();

        // Type 011 partial release, then a queued packet after one dead cycle.
        send(3'd3, 16'h0001); step();
        chk("t011_en", 32'(en_out), 32'h9);
        newpkt = 1'b1; fPktType = 3'd1; destinationID = 16'h0001;
        dest_done = 4'b0001; step();
        chk("t011_partial", 32'(en_out), 32'h8);
        dest_done = 4'b1000; step();
        chk("t011_idle", 32'(busy), 32'h0);
        step();
        chk("b2b_en", 32'(en_out), 32'h6);
        dest_done = 4'b0110; step();

        // Overflow while dispatch is held.
        send(3'd2, 16'h0001); step();
        for (int i = 0; i < 6; i++) send(3'(i), 16'h0001);
        chk("ovf_full", 32'(full), 32'h1);
        chk("ovf_drop", 32'(drop_cnt), 32'h2);
        for (int i = 0; i < 16; i++) begin dest_done = 4'b1111; step(); end

        // Type 111 is silent until reprogrammed.
        send(3'd7, 16'h0001); step();
        chk("t111_idle", 32'(busy), 32'h0);
        cfg_we = 1'b1; cfg_type = 3'd7; cfg_mask = 8'h04; step();
        send(3'd7, 16'h0001); step();
        chk("t111_prog", 32'(en_out), 32'h4);
        dest_done = 4'b0100; step();

        // Reset mid-dispatch restores table defaults and clears drop count.
        cfg_we = 1'b1; cfg_type = 3'd0; cfg_mask = 8'h01; step();
        send(3'd0, 16'h0001); step();
        chk("rst_pre", 32'(en_out), 32'h1);
        rst = 1'b1; step();
        chk("rst_en", 32'(en_out), 32'h0);
        chk("rst_drop", 32'(drop_cnt), 32'h0);
        send(3'd0, 16'h0001); step();
        chk("rst_table", 32'(en_out), 32'hA);
        dest_done = 4'b1111; step();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            newpkt = ($urandom_range(0, 99) < 45);
            fPktType = 3'($urandom);
            case ($urandom_range(0, 3))
                0:       destinationID = myNodeID;
                1:       destinationID = 16'hFFFF;
                default: destinationID = 16'($urandom);
            endcase
            dest_done = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
            cfg_we = ($urandom_range(0, 49) == 0);
            cfg_type = 3'($urandom);
            cfg_mask = 8'($urandom);
            if ($urandom_range(0, 199) == 0) myNodeID = 16'($urandom);
            step();
        end

        for (int i = 0; i < 20; i++) begin dest_done = 4'b1111; step(); end
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
